// File: rtl/mips_alu_pkg.sv
// Shared definitions for the MIPS32 ALU issue path: ALU op codes,
// opcode/funct encodings, the issue payload and the skid buffer states.
package mips_alu_pkg;

    // ALU operation codes
    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_XOR  = 4'd2;
    localparam logic [3:0] ALU_NOR  = 4'd3;
    localparam logic [3:0] ALU_ADD  = 4'd4;
    localparam logic [3:0] ALU_SUB  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_LUI  = 4'd9;
    localparam logic [3:0] ALU_SLT  = 4'd10;
    localparam logic [3:0] ALU_SLTU = 4'd11;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Payload handed from the issue stage to EX
    typedef struct packed {
        logic [3:0]  alu_ctrl;
        logic [31:0] src_a;
        logic [31:0] src_b;
        logic [4:0]  dst;
        logic        reg_write;
        logic        illegal;
    } issue_t;

    // Skid buffer occupancy, encoded as {out_valid, skid_valid}
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_FULL1 = 2'b10,
        SKID_FULL2 = 2'b11
    } skid_state_e;

    function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational decode of an ALU-class MIPS32 instruction into the
// ALU op code, both operands and the write-back destination.
module alu_op_decoder
    import mips_alu_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output issue_t      payload
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic        unused_rs_field;

    assign opcode = instr[31:26];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm    = instr[15:0];

    // rs arrives already resolved as rs_data
    assign unused_rs_field = ^instr[25:21];

    logic        legal;
    logic [3:0]  ctrl;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [4:0]  dst;

    // Select op code, operands and destination; anything unmatched is illegal
    always_comb begin
        legal = 1'b0;
        ctrl  = ALU_AND;
        src_a = rs_data;
        src_b = rt_data;
        dst   = rd;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_AND:           begin legal = 1'b1; ctrl = ALU_AND;  end
                FN_OR:            begin legal = 1'b1; ctrl = ALU_OR;   end
                FN_XOR:           begin legal = 1'b1; ctrl = ALU_XOR;  end
                FN_NOR:           begin legal = 1'b1; ctrl = ALU_NOR;  end
                FN_ADD, FN_ADDU:  begin legal = 1'b1; ctrl = ALU_ADD;  end
                FN_SUB, FN_SUBU:  begin legal = 1'b1; ctrl = ALU_SUB;  end
                FN_SLT:           begin legal = 1'b1; ctrl = ALU_SLT;  end
                FN_SLTU:          begin legal = 1'b1; ctrl = ALU_SLTU; end
                FN_SLL:  begin legal = 1'b1; ctrl = ALU_SLL; src_a = {27'b0, shamt}; end
                FN_SRL:  begin legal = 1'b1; ctrl = ALU_SRL; src_a = {27'b0, shamt}; end
                FN_SRA:  begin legal = 1'b1; ctrl = ALU_SRA; src_a = {27'b0, shamt}; end
                FN_SLLV:          begin legal = 1'b1; ctrl = ALU_SLL;  end
                FN_SRLV:          begin legal = 1'b1; ctrl = ALU_SRL;  end
                FN_SRAV:          begin legal = 1'b1; ctrl = ALU_SRA;  end
                default:          legal = 1'b0;
            endcase
        end else begin
            dst = rt;
            case (opcode)
                OP_ADDI, OP_ADDIU: begin legal = 1'b1; ctrl = ALU_ADD;  src_b = sign_ext16(imm); end
                OP_SLTI:           begin legal = 1'b1; ctrl = ALU_SLT;  src_b = sign_ext16(imm); end
                OP_SLTIU:          begin legal = 1'b1; ctrl = ALU_SLTU; src_b = sign_ext16(imm); end
                OP_ANDI:           begin legal = 1'b1; ctrl = ALU_AND;  src_b = {16'b0, imm};    end
                OP_ORI:            begin legal = 1'b1; ctrl = ALU_OR;   src_b = {16'b0, imm};    end
                OP_XORI:           begin legal = 1'b1; ctrl = ALU_XOR;  src_b = {16'b0, imm};    end
                OP_LUI: begin
                    legal = 1'b1;
                    ctrl  = ALU_LUI;
                    src_a = '0;
                    src_b = {16'b0, imm};
                end
                default:           legal = 1'b0;
            endcase
        end
    end

    // Illegal encodings travel as a zeroed payload flagged illegal
    always_comb begin
        payload = '0;
        if (legal) begin
            payload.alu_ctrl  = ctrl;
            payload.src_a     = src_a;
            payload.src_b     = src_b;
            payload.dst       = dst;
            payload.reg_write = 1'b1;
        end else begin
            payload.illegal   = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decodes an ALU instruction and presents it to EX
// through a registered output plus a one-entry skid buffer.
module alu_issue_stage
    import mips_alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs_data,
    input  logic [31:0] in_rt_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_alu_ctrl,
    output logic [31:0] out_src_a,
    output logic [31:0] out_src_b,
    output logic [4:0]  out_dst,
    output logic        out_reg_write,
    output logic        out_illegal
);

    skid_state_e state_q;
    skid_state_e state_d;
    issue_t      dec;
    issue_t      out_q;
    issue_t      skid_q;
    logic        skid_valid;
    logic        in_xfer;
    logic        load_out_from_in;
    logic        load_out_from_skid;
    logic        load_skid;

    alu_op_decoder u_dec (
        .instr   (in_instr),
        .rs_data (in_rs_data),
        .rt_data (in_rt_data),
        .payload (dec)
    );

    assign out_valid  = (state_q != SKID_EMPTY);
    assign skid_valid = (state_q == SKID_FULL2);
    assign in_ready   = rst_n & ~skid_valid;
    assign in_xfer    = in_valid & in_ready;

    // Occupancy transitions and which register captures what; flush
    // suppresses every load so an incoming entry is simply dropped
    always_comb begin
        state_d            = state_q;
        load_out_from_in   = 1'b0;
        load_out_from_skid = 1'b0;
        load_skid          = 1'b0;
        if (flush) begin
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (in_xfer) begin
                        state_d          = SKID_FULL1;
                        load_out_from_in = 1'b1;
                    end
                end
                SKID_FULL1: begin
                    if (in_xfer && out_ready) begin
                        load_out_from_in = 1'b1;
                    end else if (in_xfer) begin
                        state_d   = SKID_FULL2;
                        load_skid = 1'b1;
                    end else if (out_ready) begin
                        state_d = SKID_EMPTY;
                    end
                end
                SKID_FULL2: begin
                    if (out_ready) begin
                        state_d            = SKID_FULL1;
                        load_out_from_skid = 1'b1;
                    end
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
    end

    // Occupancy register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= SKID_EMPTY;
        else        state_q <= state_d;
    end

    // Output and skid payload registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out_from_in)        out_q <= dec;
            else if (load_out_from_skid) out_q <= skid_q;
            if (load_skid)               skid_q <= dec;
        end
    end

    assign out_alu_ctrl  = out_q.alu_ctrl;
    assign out_src_a     = out_q.src_a;
    assign out_src_b     = out_q.src_b;
    assign out_dst       = out_q.dst;
    assign out_reg_write = out_q.reg_write;
    assign out_illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized self-checking bench for alu_issue_stage against a queue-based
// reference model with an independent instruction decoder.
module tb_alu_issue_stage;
    import mips_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_rs_data = '0;
    logic [31:0] in_rt_data = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_alu_ctrl;
    logic [31:0] out_src_a;
    logic [31:0] out_src_b;
    logic [4:0]  out_dst;
    logic        out_reg_write;
    logic        out_illegal;

    int unsigned n_vectors = 0;
    int unsigned n_miscompares = 0;
    int unsigned dut_out_cnt = 0;
    logic        last_accept = 1'b0;
    issue_t      mq[$];
    logic [74:0] dut_payload;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_rs_data    (in_rs_data),
        .in_rt_data    (in_rt_data),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_alu_ctrl  (out_alu_ctrl),
        .out_src_a     (out_src_a),
        .out_src_b     (out_src_b),
        .out_dst       (out_dst),
        .out_reg_write (out_reg_write),
        .out_illegal   (out_illegal)
    );

    assign dut_payload = {out_alu_ctrl, out_src_a, out_src_b, out_dst, out_reg_write, out_illegal};

    task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decode written from the instruction tables
    function automatic issue_t ref_decode(input logic [31:0] w, input logic [31:0] rs, input logic [31:0] rt);
        issue_t      r;
        int          ctrl = -1;
        logic [31:0] a = rs;
        logic [31:0] b = rt;
        logic [4:0]  d;
        logic [5:0]  op = w[31:26];
        logic [5:0]  fn = w[5:0];
        logic [15:0] imm = w[15:0];
        logic [31:0] sx = 32'($signed(imm));
        logic [31:0] zx = 32'(imm);
        if (op == 6'd0) begin
            d = w[15:11];
            case (fn)
                6'h24: ctrl = 0;
                6'h25: ctrl = 1;
                6'h26: ctrl = 2;
                6'h27: ctrl = 3;
                6'h20, 6'h21: ctrl = 4;
                6'h22, 6'h23: ctrl = 5;
                6'h2A: ctrl = 10;
                6'h2B: ctrl = 11;
                6'h00: begin ctrl = 6; a = 32'(w[10:6]); end
                6'h02: begin ctrl = 7; a = 32'(w[10:6]); end
                6'h03: begin ctrl = 8; a = 32'(w[10:6]); end
                6'h04: ctrl = 6;
                6'h06: ctrl = 7;
                6'h07: ctrl = 8;
                default: ctrl = -1;
            endcase
        end else begin
            d = w[20:16];
            case (op)
                6'h08, 6'h09: begin ctrl = 4;  b = sx; end
                6'h0A:        begin ctrl = 10; b = sx; end
                6'h0B:        begin ctrl = 11; b = sx; end
                6'h0C:        begin ctrl = 0;  b = zx; end
                6'h0D:        begin ctrl = 1;  b = zx; end
                6'h0E:        begin ctrl = 2;  b = zx; end
                6'h0F:        begin ctrl = 9;  a = 32'd0; b = zx; end
                default:      ctrl = -1;
            endcase
        end
        if (ctrl < 0) r = '{alu_ctrl: 4'd0, src_a: 32'd0, src_b: 32'd0, dst: 5'd0, reg_write: 1'b0, illegal: 1'b1};
        else          r = '{alu_ctrl: 4'(ctrl), src_a: a, src_b: b, dst: d, reg_write: 1'b1, illegal: 1'b0};
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom;
        logic [5:0]  fns[16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                                 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
        case ($urandom_range(0, 3))
            0: begin w[31:26] = 6'd0; w[5:0] = fns[$urandom_range(0, 15)]; end
            1: w[31:26] = 6'(8 + $urandom_range(0, 7));
            2: w[31:26] = 6'd0;
            default: ;
        endcase
        return w;
    endfunction

    // One clock: drive, check in_ready, advance the model, then check outputs
    task automatic cycle(input logic rn, input logic iv, input logic fl, input logic ordy,
                         input logic [31:0] w, input logic [31:0] rs, input logic [31:0] rt);
        logic exp_ir;
        rst_n = rn; in_valid = iv; flush = fl; out_ready = ordy;
        in_instr = w; in_rs_data = rs; in_rt_data = rt;
        #1;
        exp_ir = rn && (mq.size() < 2);
        check_eq("in_ready", 96'(in_ready), 96'(exp_ir));
        if (out_valid && out_ready) dut_out_cnt++;
        last_accept = 1'b0;
        if (!rn || fl) begin
            mq.delete();
        end else begin
            if (mq.size() > 0 && ordy) void'(mq.pop_front());
            if (iv && exp_ir) begin
                mq.push_back(ref_decode(w, rs, rt));
                last_accept = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check_eq("out_valid", 96'(out_valid), 96'(mq.size() > 0));
        if (mq.size() > 0) check_eq("payload", 96'(dut_payload), 96'(mq[0]));
    endtask

    task automatic check_fields(input string tag, input logic [3:0] c, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] d, input logic rw, input logic ill);
        check_eq({tag, "_valid"}, 96'(out_valid), 96'(1));
        check_eq({tag, "_ctrl"},  96'(out_alu_ctrl), 96'(c));
        check_eq({tag, "_src_a"}, 96'(out_src_a), 96'(a));
        check_eq({tag, "_src_b"}, 96'(out_src_b), 96'(b));
        check_eq({tag, "_dst"},   96'(out_dst), 96'(d));
        check_eq({tag, "_rw"},    96'(out_reg_write), 96'(rw));
        check_eq({tag, "_ill"},   96'(out_illegal), 96'(ill));
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] si[6];
        logic [31:0] sr[6];
        logic [31:0] st[6];
        int unsigned k;

        // reset
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h2128FFFF, 32'd1, 32'd2);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0);
        check_eq("rst_out_valid", 96'(out_valid), 96'(0));
        check_eq("rst_payload", 96'(dut_payload), 96'(0));

        // directed decode vectors, streamed back to back
        r = $urandom;
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h2128FFFF, 32'd5, r);
        check_fields("addi", 4'd4, 32'd5, 32'hFFFFFFFF, 5'd8, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h00094100, r, 32'h0000000F);
        check_fields("sll", 4'd6, 32'd4, 32'h0000000F, 5'd8, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h3C081234, r, r);
        check_fields("lui", 4'd9, 32'd0, 32'h00001234, 5'd8, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h35088000, r, 32'd7);
        check_fields("ori", 4'd1, r, 32'h00008000, 5'd8, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'hFC000000, r, r);
        check_fields("illegal", 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
        dut_out_cnt = 0;
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0);
        check_eq("illegal_drained", 96'(dut_out_cnt), 96'(1));

        // six instructions with EX stalled for the first three cycles
        for (int i = 0; i < 6; i++) begin
            si[i] = rand_instr(); sr[i] = $urandom; st[i] = $urandom;
        end
        k = 0;
        dut_out_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (k == 6 && mq.size() == 0) break;
            cycle(1'b1, k < 6, 1'b0, c >= 3, si[k < 6 ? k : 0], sr[k < 6 ? k : 0], st[k < 6 ? k : 0]);
            if (c == 1) check_eq("stall_in_ready", 96'(in_ready), 96'(0));
            if (last_accept) k++;
        end
        check_eq("stall_out_count", 96'(dut_out_cnt), 96'(6));

        // flush while both entries are held, with an input offered
        cycle(1'b1, 1'b1, 1'b0, 1'b0, rand_instr(), $urandom, $urandom);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, rand_instr(), $urandom, $urandom);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, rand_instr(), $urandom, $urandom);
        check_eq("flush_out_valid", 96'(out_valid), 96'(0));
        check_eq("flush_in_ready", 96'(in_ready), 96'(1));
        dut_out_cnt = 0;
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0);
        check_eq("flush_no_output", 96'(dut_out_cnt), 96'(0));

        // flush with one entry, simultaneous input and output transfer
        cycle(1'b1, 1'b1, 1'b0, 1'b0, rand_instr(), $urandom, $urandom);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, rand_instr(), $urandom, $urandom);
        check_eq("flush1_out_valid", 96'(out_valid), 96'(0));

        // reset while both entries are held
        cycle(1'b1, 1'b1, 1'b0, 1'b0, rand_instr(), $urandom, $urandom);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, rand_instr(), $urandom, $urandom);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, rand_instr(), $urandom, $urandom);
        check_eq("rst_full2_out_valid", 96'(out_valid), 96'(0));
        check_eq("rst_full2_in_ready", 96'(in_ready), 96'(0));
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0);
        check_eq("rst_release_in_ready", 96'(in_ready), 96'(1));
        check_eq("rst_release_out_valid", 96'(out_valid), 96'(0));

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0,
                  rand_instr(), $urandom, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Registered ID→EX issue stage that decodes a MIPS32 ALU-class instruction into the 4-bit ALU operation code and the two ALU operands (SrcA, SrcB), then hands them to the execute stage over a valid/ready handshake. It is the producer side of the ALU's operand/operation interface. A one-entry skid buffer provides full throughput with a registered `in_ready`. Pipeline flush is supported.

## Interface
- No parameters. Operand width is fixed at 32 bits and the op code at 4 bits.
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — synchronous reset, active-low.
- `in_valid` in 1 — decode stage presents an instruction.
- `in_ready` out 1 — stage can accept. Equals `rst_n & ~skid_valid`.
- `in_instr` in 32 — instruction word.
- `in_rs_data` in 32 — forwarded rs register value.
- `in_rt_data` in 32 — forwarded rt register value.
- `flush` in 1 — discard all held and incoming instructions.
- `out_valid` out 1 — EX payload valid.
- `out_ready` in 1 — EX accepts.
- `out_alu_ctrl` out 4 — ALU operation code.
- `out_src_a` out 32 — ALU SrcA.
- `out_src_b` out 32 — ALU SrcB.
- `out_dst` out 5 — destination register.
- `out_reg_write` out 1 — result is written back.
- `out_illegal` out 1 — opcode/funct not supported.

## Operation
- ALU codes: AND=0, OR=1, XOR=2, NOR=3, ADD=4, SUB=5, SLL=6, SRL=7, SRA=8, LUI=9, SLT=10, SLTU=11.
- Shifts: the ALU shifts SrcB by SrcA[4:0].
- R-type (opcode 0x00), by funct:
  - 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR.
  - 0x20/0x21 ADD, 0x22/0x23 SUB.
  - 0x2A SLT, 0x2B SLTU.
  - For all of the above: SrcA=rs_data, SrcB=rt_data.
  - 0x00 SLL, 0x02 SRL, 0x03 SRA: SrcA={27'b0, shamt}, SrcB=rt_data.
  - 0x04 SLLV, 0x06 SRLV, 0x07 SRAV: SrcA=rs_data, SrcB=rt_data.
  - Destination = rd.
- I-type, with destination = rt and SrcA = rs_data:
  - 0x08/0x09 ADD with sign-extended imm.
  - 0x0A SLT and 0x0B SLTU, both with sign-extended imm.
  - 0x0C AND, 0x0D OR, 0x0E XOR, all with zero-extended imm.
  - 0x0F LUI: SrcB={16'b0, imm}, SrcA=0.
- Any other opcode/funct:
  - `out_illegal`=1, `out_reg_write`=0, alu_ctrl=AND, operands=0, dst=0.
  - Still passes through the handshake.
- Legal instructions: `out_reg_write`=1. Destination 0 is not special-cased.
- Decode is combinational on the input side; the result is captured into the output register or the skid register.
- Skid state machine, state = {out_valid, skid_valid}:
  - EMPTY (0,0): accept → FULL1.
  - FULL1 (1,0):
    - Input and output transfer together → stay FULL1.
    - Output transfer only → EMPTY.
    - Input transfer without `out_ready` → FULL2 (entry goes to skid).
  - FULL2 (1,1): `in_ready`=0.
    - Output transfer → skid moves to output → FULL1.
- Output order always equals input acceptance order.

## Timing
- Reset (`rst_n`=0 at an edge): all output registers and the skid register clear to 0.
  - `out_valid`=0, `in_ready`=0 while `rst_n`=0, then 1 in the first cycle after release.
- Latency: accepted at edge N → `out_valid` from edge N, visible in cycle N+1.
- Throughput: 1 instruction/cycle while `out_ready`=1.
- Output payload is stable while `out_valid`=1 and `out_ready`=0.
- `flush`=1 at an edge:
  - Both entries are invalidated.
  - A simultaneous input transfer is dropped.
  - A simultaneous output transfer still counts as completed by EX.
  - Next state = EMPTY.
- `flush` and `rst_n`=0 together: reset wins (same result).
- Reset mid-stall (FULL2): both entries are lost. No partial output.

## Structure
- Shared package `mips_alu_pkg` holds:
  - The 4-bit ALU op constants.
  - Opcode and funct constants.
  - A packed issue-payload struct: alu_ctrl, src_a, src_b, dst, reg_write, illegal.
- Sub-module `alu_op_decoder` (combinational): instr + rs/rt data → payload struct.
- The top level holds the skid/handshake logic only.

## Test plan
- `0x2128FFFF` (addi $8,$9,-1), rs_data=5 → next cycle: ctrl=4, src_a=5, src_b=0xFFFFFFFF, dst=8, reg_write=1.
- `0x00094100` (sll $8,$9,4), rt_data=0x0000000F → ctrl=6, src_a=4, src_b=0x0000000F, dst=8.
- `0x3C081234` (lui) → ctrl=9, src_a=0, src_b=0x00001234. `0x35088000` (ori) → ctrl=1, src_b=0x00008000 (zero-extended).
- `0xFC000000` → illegal=1, reg_write=0, ctrl=0; handshake still completes.
- Back-to-back stream of 6 instructions, `out_ready` low for 3 cycles → `in_ready` drops after the second accept; all 6 emerge in order, none duplicated.
- FULL2 then `flush`=1 with `in_valid`=1 → `out_valid`=0 and `in_ready`=1 next cycle; the flushed entries never appear. Reset asserted in FULL2 gives the same result.
